// File: rtl/vxe_axi4_defs.sv
// AXI4 response/burst encodings and size helper shared by the VxEngine AXI4
// master and slave bus interface units.
package vxe_axi4_defs;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    // AxSIZE encoding for a full-width beat.
    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

    // SLVERR and DECERR both carry bit 1; OKAY and EXOKAY are success.
    function automatic logic axi_resp_is_error(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/vxe_axi4mas_biu_if.sv
// AXI4 bus bundle between the VxEngine master BIU and the system interconnect.
interface vxe_axi4mas_biu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]     M_AXI4_AWID;
    logic [ADDR_WIDTH-1:0]   M_AXI4_AWADDR;
    logic [7:0]              M_AXI4_AWLEN;
    logic [2:0]              M_AXI4_AWSIZE;
    logic [1:0]              M_AXI4_AWBURST;
    logic                    M_AXI4_AWLOCK;
    logic [2:0]              M_AXI4_AWPROT;
    logic                    M_AXI4_AWVALID;
    logic                    M_AXI4_AWREADY;

    logic [DATA_WIDTH-1:0]   M_AXI4_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI4_WSTRB;
    logic                    M_AXI4_WLAST;
    logic                    M_AXI4_WVALID;
    logic                    M_AXI4_WREADY;

    logic [ID_WIDTH-1:0]     M_AXI4_BID;
    logic [1:0]              M_AXI4_BRESP;
    logic                    M_AXI4_BVALID;
    logic                    M_AXI4_BREADY;

    logic [ID_WIDTH-1:0]     M_AXI4_ARID;
    logic [ADDR_WIDTH-1:0]   M_AXI4_ARADDR;
    logic [7:0]              M_AXI4_ARLEN;
    logic [2:0]              M_AXI4_ARSIZE;
    logic [1:0]              M_AXI4_ARBURST;
    logic                    M_AXI4_ARLOCK;
    logic [2:0]              M_AXI4_ARPROT;
    logic                    M_AXI4_ARVALID;
    logic                    M_AXI4_ARREADY;

    logic [ID_WIDTH-1:0]     M_AXI4_RID;
    logic [DATA_WIDTH-1:0]   M_AXI4_RDATA;
    logic [1:0]              M_AXI4_RRESP;
    logic                    M_AXI4_RLAST;
    logic                    M_AXI4_RVALID;
    logic                    M_AXI4_RREADY;

    modport master (
        output M_AXI4_AWID, M_AXI4_AWADDR, M_AXI4_AWLEN, M_AXI4_AWSIZE,
               M_AXI4_AWBURST, M_AXI4_AWLOCK, M_AXI4_AWPROT, M_AXI4_AWVALID,
        input  M_AXI4_AWREADY,
        output M_AXI4_WDATA, M_AXI4_WSTRB, M_AXI4_WLAST, M_AXI4_WVALID,
        input  M_AXI4_WREADY,
        input  M_AXI4_BID, M_AXI4_BRESP, M_AXI4_BVALID,
        output M_AXI4_BREADY,
        output M_AXI4_ARID, M_AXI4_ARADDR, M_AXI4_ARLEN, M_AXI4_ARSIZE,
               M_AXI4_ARBURST, M_AXI4_ARLOCK, M_AXI4_ARPROT, M_AXI4_ARVALID,
        input  M_AXI4_ARREADY,
        input  M_AXI4_RID, M_AXI4_RDATA, M_AXI4_RRESP, M_AXI4_RLAST, M_AXI4_RVALID,
        output M_AXI4_RREADY
    );

    modport slave (
        input  M_AXI4_AWID, M_AXI4_AWADDR, M_AXI4_AWLEN, M_AXI4_AWSIZE,
               M_AXI4_AWBURST, M_AXI4_AWLOCK, M_AXI4_AWPROT, M_AXI4_AWVALID,
        output M_AXI4_AWREADY,
        input  M_AXI4_WDATA, M_AXI4_WSTRB, M_AXI4_WLAST, M_AXI4_WVALID,
        output M_AXI4_WREADY,
        output M_AXI4_BID, M_AXI4_BRESP, M_AXI4_BVALID,
        input  M_AXI4_BREADY,
        input  M_AXI4_ARID, M_AXI4_ARADDR, M_AXI4_ARLEN, M_AXI4_ARSIZE,
               M_AXI4_ARBURST, M_AXI4_ARLOCK, M_AXI4_ARPROT, M_AXI4_ARVALID,
        output M_AXI4_ARREADY,
        output M_AXI4_RID, M_AXI4_RDATA, M_AXI4_RRESP, M_AXI4_RLAST, M_AXI4_RVALID,
        input  M_AXI4_RREADY
    );

endinterface

// File: rtl/vxe_axi4mas_biu.sv
// AXI4 master BIU: turns single-word request/done client traffic into
// single-beat AXI4 transactions; read and write paths run independently.
module vxe_axi4mas_biu
    import vxe_axi4_defs::*;
#(
    parameter int                ADDR_WIDTH = 32,
    parameter int                DATA_WIDTH = 32,
    parameter int                ID_WIDTH   = 8,
    parameter logic [ID_WIDTH-1:0] AXI_ID   = '0
) (
    input  logic                    M_AXI4_ACLK,
    input  logic                    M_AXI4_ARESETn,
    vxe_axi4mas_biu_if.master       m_axi,

    input  logic [ADDR_WIDTH-1:0]   biu_waddr,
    input  logic [DATA_WIDTH-1:0]   biu_wdata,
    input  logic [DATA_WIDTH/8-1:0] biu_wben,
    input  logic                    biu_wenable,
    output logic                    biu_waccept,
    output logic                    biu_wdone,
    output logic                    biu_werror,

    input  logic [ADDR_WIDTH-1:0]   biu_raddr,
    input  logic                    biu_renable,
    output logic                    biu_raccept,
    output logic                    biu_rdone,
    output logic [DATA_WIDTH-1:0]   biu_rdata,
    output logic                    biu_rerror
);

    localparam logic [2:0] AX_SIZE = axi_size(DATA_WIDTH);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rstate_e;

    // Fixed single-beat INCR attributes on both address channels.
    assign m_axi.M_AXI4_AWID    = AXI_ID;
    assign m_axi.M_AXI4_AWLEN   = 8'd0;
    assign m_axi.M_AXI4_AWSIZE  = AX_SIZE;
    assign m_axi.M_AXI4_AWBURST = AXI_BURST_INCR;
    assign m_axi.M_AXI4_AWLOCK  = 1'b0;
    assign m_axi.M_AXI4_AWPROT  = 3'b000;
    assign m_axi.M_AXI4_WLAST   = 1'b1;
    assign m_axi.M_AXI4_ARID    = AXI_ID;
    assign m_axi.M_AXI4_ARLEN   = 8'd0;
    assign m_axi.M_AXI4_ARSIZE  = AX_SIZE;
    assign m_axi.M_AXI4_ARBURST = AXI_BURST_INCR;
    assign m_axi.M_AXI4_ARLOCK  = 1'b0;
    assign m_axi.M_AXI4_ARPROT  = 3'b000;

    // IDs are irrelevant with a single outstanding transaction per path.
    logic unused_resp_bits;
    assign unused_resp_bits = ^{m_axi.M_AXI4_BID, m_axi.M_AXI4_RID,
                                m_axi.M_AXI4_BRESP[0], m_axi.M_AXI4_RRESP[0]};

    // ---------------- write path ----------------
    wstate_e                 wstate_reg, wstate_next;
    logic [ADDR_WIDTH-1:0]   awaddr_reg, awaddr_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic [DATA_WIDTH/8-1:0] wstrb_reg, wstrb_next;
    logic                    awpend_reg, awpend_next;
    logic                    wpend_reg, wpend_next;
    logic                    wdone_reg, wdone_next;
    logic                    werror_reg, werror_next;

    always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
        if (!M_AXI4_ARESETn) begin
            wstate_reg <= W_IDLE;
            awaddr_reg <= '0;
            wdata_reg  <= '0;
            wstrb_reg  <= '0;
            awpend_reg <= 1'b0;
            wpend_reg  <= 1'b0;
            wdone_reg  <= 1'b0;
            werror_reg <= 1'b0;
        end else begin
            wstate_reg <= wstate_next;
            awaddr_reg <= awaddr_next;
            wdata_reg  <= wdata_next;
            wstrb_reg  <= wstrb_next;
            awpend_reg <= awpend_next;
            wpend_reg  <= wpend_next;
            wdone_reg  <= wdone_next;
            werror_reg <= werror_next;
        end
    end

    always_comb begin
        wstate_next = wstate_reg;
        awaddr_next = awaddr_reg;
        wdata_next  = wdata_reg;
        wstrb_next  = wstrb_reg;
        awpend_next = awpend_reg;
        wpend_next  = wpend_reg;
        wdone_next  = 1'b0;
        werror_next = werror_reg;
        case (wstate_reg)
            W_IDLE: begin
                if (biu_wenable) begin
                    awaddr_next = biu_waddr;
                    wdata_next  = biu_wdata;
                    wstrb_next  = biu_wben;
                    awpend_next = 1'b1;
                    wpend_next  = 1'b1;
                    wstate_next = W_REQ;
                end
            end
            W_REQ: begin
                // AW and W complete independently, in any order.
                awpend_next = awpend_reg & ~m_axi.M_AXI4_AWREADY;
                wpend_next  = wpend_reg & ~m_axi.M_AXI4_WREADY;
                if (!awpend_next && !wpend_next)
                    wstate_next = W_RESP;
            end
            W_RESP: begin
                if (m_axi.M_AXI4_BVALID) begin
                    werror_next = axi_resp_is_error(m_axi.M_AXI4_BRESP);
                    wdone_next  = 1'b1;
                    wstate_next = W_IDLE;
                end
            end
            default: wstate_next = W_IDLE;
        endcase
    end

    assign m_axi.M_AXI4_AWADDR  = awaddr_reg;
    assign m_axi.M_AXI4_AWVALID = awpend_reg;
    assign m_axi.M_AXI4_WDATA   = wdata_reg;
    assign m_axi.M_AXI4_WSTRB   = wstrb_reg;
    assign m_axi.M_AXI4_WVALID  = wpend_reg;
    assign m_axi.M_AXI4_BREADY  = (wstate_reg == W_RESP);
    assign biu_waccept          = (wstate_reg == W_IDLE);
    assign biu_wdone            = wdone_reg;
    assign biu_werror           = werror_reg;

    // ---------------- read path ----------------
    rstate_e               rstate_reg, rstate_next;
    logic [ADDR_WIDTH-1:0] araddr_reg, araddr_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic                  rdone_reg, rdone_next;
    logic                  rerror_reg, rerror_next;

    always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
        if (!M_AXI4_ARESETn) begin
            rstate_reg <= R_IDLE;
            araddr_reg <= '0;
            rdata_reg  <= '0;
            rdone_reg  <= 1'b0;
            rerror_reg <= 1'b0;
        end else begin
            rstate_reg <= rstate_next;
            araddr_reg <= araddr_next;
            rdata_reg  <= rdata_next;
            rdone_reg  <= rdone_next;
            rerror_reg <= rerror_next;
        end
    end

    always_comb begin
        rstate_next = rstate_reg;
        araddr_next = araddr_reg;
        rdata_next  = rdata_reg;
        rdone_next  = 1'b0;
        rerror_next = rerror_reg;
        case (rstate_reg)
            R_IDLE: begin
                if (biu_renable) begin
                    araddr_next = biu_raddr;
                    rstate_next = R_ADDR;
                end
            end
            R_ADDR: begin
                if (m_axi.M_AXI4_ARREADY)
                    rstate_next = R_RESP;
            end
            R_RESP: begin
                if (m_axi.M_AXI4_RVALID) begin
                    rdata_next  = m_axi.M_AXI4_RDATA;
                    // A single-beat read must carry RLAST; anything else is a protocol error.
                    rerror_next = axi_resp_is_error(m_axi.M_AXI4_RRESP) | ~m_axi.M_AXI4_RLAST;
                    rdone_next  = 1'b1;
                    rstate_next = R_IDLE;
                end
            end
            default: rstate_next = R_IDLE;
        endcase
    end

    assign m_axi.M_AXI4_ARADDR  = araddr_reg;
    assign m_axi.M_AXI4_ARVALID = (rstate_reg == R_ADDR);
    assign m_axi.M_AXI4_RREADY  = (rstate_reg == R_RESP);
    assign biu_raccept          = (rstate_reg == R_IDLE);
    assign biu_rdone            = rdone_reg;
    assign biu_rdata            = rdata_reg;
    assign biu_rerror           = rerror_reg;

endmodule

// File: tb/tb_vxe_axi4mas_biu.sv
// Directed bench for vxe_axi4mas_biu: the bench plays the AXI4 slave and the client.
module tb_vxe_axi4mas_biu;
    import vxe_axi4_defs::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] biu_waddr;
    logic [31:0] biu_wdata;
    logic [3:0]  biu_wben;
    logic        biu_wenable;
    logic        biu_waccept;
    logic        biu_wdone;
    logic        biu_werror;
    logic [31:0] biu_raddr;
    logic        biu_renable;
    logic        biu_raccept;
    logic        biu_rdone;
    logic [31:0] biu_rdata;
    logic        biu_rerror;

    int tests = 0;
    int fails = 0;
    int wdone_cnt = 0;
    int rdone_cnt = 0;
    int c0;

    vxe_axi4mas_biu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8)) axi ();

    vxe_axi4mas_biu #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8), .AXI_ID(8'h00)
    ) dut (
        .M_AXI4_ACLK    (clk),
        .M_AXI4_ARESETn (rst_n),
        .m_axi          (axi),
        .biu_waddr      (biu_waddr),
        .biu_wdata      (biu_wdata),
        .biu_wben       (biu_wben),
        .biu_wenable    (biu_wenable),
        .biu_waccept    (biu_waccept),
        .biu_wdone      (biu_wdone),
        .biu_werror     (biu_werror),
        .biu_raddr      (biu_raddr),
        .biu_renable    (biu_renable),
        .biu_raccept    (biu_raccept),
        .biu_rdone      (biu_rdone),
        .biu_rdata      (biu_rdata),
        .biu_rerror     (biu_rerror)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (biu_wdone) wdone_cnt <= wdone_cnt + 1;
        if (biu_rdone) rdone_cnt <= rdone_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Zero-wait read: accept, AR handshake next cycle, response the cycle after.
    task automatic zw_read(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input logic last, input logic exp_err);
        axi.M_AXI4_ARREADY = 1'b1;
        biu_raddr = addr;
        biu_renable = 1'b1;
        check({tag, "_raccept"}, 64'(biu_raccept), 64'd1);
        tick();
        biu_renable = 1'b0;
        check({tag, "_arvalid"}, 64'(axi.M_AXI4_ARVALID), 64'd1);
        check({tag, "_araddr"}, 64'(axi.M_AXI4_ARADDR), 64'(addr));
        tick();
        check({tag, "_rready"}, 64'(axi.M_AXI4_RREADY), 64'd1);
        axi.M_AXI4_RVALID = 1'b1;
        axi.M_AXI4_RDATA  = data;
        axi.M_AXI4_RRESP  = resp;
        axi.M_AXI4_RLAST  = last;
        tick();
        axi.M_AXI4_RVALID = 1'b0;
        axi.M_AXI4_RLAST  = 1'b1;
        check({tag, "_rdone"}, 64'(biu_rdone), 64'd1);
        check({tag, "_rdata"}, 64'(biu_rdata), 64'(data));
        check({tag, "_rerror"}, 64'(biu_rerror), 64'(exp_err));
        tick();
        check({tag, "_rdone_clr"}, 64'(biu_rdone), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        biu_waddr = '0; biu_wdata = '0; biu_wben = '0; biu_wenable = 1'b0;
        biu_raddr = '0; biu_renable = 1'b0;
        axi.M_AXI4_AWREADY = 1'b0; axi.M_AXI4_WREADY = 1'b0;
        axi.M_AXI4_BID = 8'h5A; axi.M_AXI4_BRESP = 2'b00; axi.M_AXI4_BVALID = 1'b0;
        axi.M_AXI4_ARREADY = 1'b0;
        axi.M_AXI4_RID = 8'hA5; axi.M_AXI4_RDATA = '0; axi.M_AXI4_RRESP = 2'b00;
        axi.M_AXI4_RLAST = 1'b1; axi.M_AXI4_RVALID = 1'b0;
        tick(); tick();

        // Reset state and constant attributes
        check("rst_awvalid", 64'(axi.M_AXI4_AWVALID), 64'd0);
        check("rst_wvalid", 64'(axi.M_AXI4_WVALID), 64'd0);
        check("rst_arvalid", 64'(axi.M_AXI4_ARVALID), 64'd0);
        check("rst_bready", 64'(axi.M_AXI4_BREADY), 64'd0);
        check("rst_rready", 64'(axi.M_AXI4_RREADY), 64'd0);
        check("rst_waccept", 64'(biu_waccept), 64'd1);
        check("rst_raccept", 64'(biu_raccept), 64'd1);
        check("rst_wdone", 64'(biu_wdone), 64'd0);
        check("rst_rdone", 64'(biu_rdone), 64'd0);
        check("rst_werror", 64'(biu_werror), 64'd0);
        check("rst_rerror", 64'(biu_rerror), 64'd0);
        check("rst_rdata", 64'(biu_rdata), 64'd0);
        check("rst_awaddr", 64'(axi.M_AXI4_AWADDR), 64'd0);
        check("rst_wdata", 64'(axi.M_AXI4_WDATA), 64'd0);
        check("const_awlen", 64'(axi.M_AXI4_AWLEN), 64'd0);
        check("const_arsize", 64'(axi.M_AXI4_ARSIZE), 64'd2);
        check("const_awburst", 64'(axi.M_AXI4_AWBURST), 64'd1);
        check("const_wlast", 64'(axi.M_AXI4_WLAST), 64'd1);
        check("const_arid", 64'(axi.M_AXI4_ARID), 64'd0);
        rst_n = 1'b1;
        tick();

        // Write 1: zero-wait slave, OKAY
        axi.M_AXI4_AWREADY = 1'b1; axi.M_AXI4_WREADY = 1'b1;
        biu_waddr = 32'h0000_1000; biu_wdata = 32'hDEAD_BEEF; biu_wben = 4'hF;
        biu_wenable = 1'b1;
        check("w1_waccept", 64'(biu_waccept), 64'd1);
        tick();
        biu_wenable = 1'b0;
        check("w1_awvalid", 64'(axi.M_AXI4_AWVALID), 64'd1);
        check("w1_wvalid", 64'(axi.M_AXI4_WVALID), 64'd1);
        check("w1_awaddr", 64'(axi.M_AXI4_AWADDR), 64'h1000);
        check("w1_wdata", 64'(axi.M_AXI4_WDATA), 64'hDEADBEEF);
        check("w1_wstrb", 64'(axi.M_AXI4_WSTRB), 64'hF);
        check("w1_waccept_busy", 64'(biu_waccept), 64'd0);
        tick();
        check("w1_bready", 64'(axi.M_AXI4_BREADY), 64'd1);
        check("w1_awvalid_clr", 64'(axi.M_AXI4_AWVALID), 64'd0);
        check("w1_wdone_early", 64'(biu_wdone), 64'd0);
        axi.M_AXI4_BVALID = 1'b1; axi.M_AXI4_BRESP = AXI_RESP_OKAY;
        tick();
        axi.M_AXI4_BVALID = 1'b0;
        check("w1_wdone", 64'(biu_wdone), 64'd1);
        check("w1_werror", 64'(biu_werror), 64'd0);
        check("w1_waccept_done", 64'(biu_waccept), 64'd1);
        check("w1_bready_clr", 64'(axi.M_AXI4_BREADY), 64'd0);
        tick();
        check("w1_wdone_clr", 64'(biu_wdone), 64'd0);

        // Write 2: W handshake three cycles before AW, SLVERR
        axi.M_AXI4_AWREADY = 1'b0; axi.M_AXI4_WREADY = 1'b0;
        c0 = wdone_cnt;
        biu_waddr = 32'h0000_3000; biu_wdata = 32'hCAFE_F00D; biu_wben = 4'h3;
        biu_wenable = 1'b1;
        tick();
        biu_wenable = 1'b0;
        axi.M_AXI4_WREADY = 1'b1;
        check("w2_wvalid", 64'(axi.M_AXI4_WVALID), 64'd1);
        tick();
        axi.M_AXI4_WREADY = 1'b0;
        check("w2_wvalid_drop", 64'(axi.M_AXI4_WVALID), 64'd0);
        check("w2_awvalid_hold", 64'(axi.M_AXI4_AWVALID), 64'd1);
        tick();
        check("w2_awvalid_hold2", 64'(axi.M_AXI4_AWVALID), 64'd1);
        check("w2_bready_wait", 64'(axi.M_AXI4_BREADY), 64'd0);
        tick();
        axi.M_AXI4_AWREADY = 1'b1;
        check("w2_awvalid_hs", 64'(axi.M_AXI4_AWVALID), 64'd1);
        check("w2_awaddr_stable", 64'(axi.M_AXI4_AWADDR), 64'h3000);
        check("w2_wstrb_stable", 64'(axi.M_AXI4_WSTRB), 64'h3);
        tick();
        axi.M_AXI4_AWREADY = 1'b0;
        check("w2_awvalid_clr", 64'(axi.M_AXI4_AWVALID), 64'd0);
        check("w2_bready", 64'(axi.M_AXI4_BREADY), 64'd1);
        axi.M_AXI4_BVALID = 1'b1; axi.M_AXI4_BRESP = AXI_RESP_SLVERR;
        tick();
        axi.M_AXI4_BVALID = 1'b0;
        check("w2_wdone", 64'(biu_wdone), 64'd1);
        check("w2_werror", 64'(biu_werror), 64'd1);
        tick(); tick();
        check("w2_wdone_once", 64'(wdone_cnt - c0), 64'd1);
        check("w2_werror_hold", 64'(biu_werror), 64'd1);

        // Read A: 5-cycle ARREADY stall, early RVALID ignored, SLVERR
        axi.M_AXI4_ARREADY = 1'b0;
        biu_raddr = 32'h0000_2004; biu_renable = 1'b1;
        check("rA_raccept", 64'(biu_raccept), 64'd1);
        tick();
        biu_renable = 1'b0;
        axi.M_AXI4_RVALID = 1'b1; axi.M_AXI4_RDATA = 32'h1234_5678;
        axi.M_AXI4_RRESP = AXI_RESP_SLVERR; axi.M_AXI4_RLAST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("rA_arvalid_stall", 64'(axi.M_AXI4_ARVALID), 64'd1);
            check("rA_araddr_stall", 64'(axi.M_AXI4_ARADDR), 64'h2004);
            check("rA_rready_stall", 64'(axi.M_AXI4_RREADY), 64'd0);
            check("rA_rdone_stall", 64'(biu_rdone), 64'd0);
            tick();
        end
        axi.M_AXI4_ARREADY = 1'b1;
        check("rA_arvalid_hs", 64'(axi.M_AXI4_ARVALID), 64'd1);
        tick();
        axi.M_AXI4_ARREADY = 1'b0;
        check("rA_arvalid_clr", 64'(axi.M_AXI4_ARVALID), 64'd0);
        check("rA_rready", 64'(axi.M_AXI4_RREADY), 64'd1);
        tick();
        axi.M_AXI4_RVALID = 1'b0;
        check("rA_rdone", 64'(biu_rdone), 64'd1);
        check("rA_rdata", 64'(biu_rdata), 64'h12345678);
        check("rA_rerror", 64'(biu_rerror), 64'd1);
        tick();
        check("rA_rdone_clr", 64'(biu_rdone), 64'd0);
        check("rA_rdata_hold", 64'(biu_rdata), 64'h12345678);

        // Read B: EXOKAY is success; Read C: missing RLAST is an error
        zw_read("rB", 32'h0000_2008, 32'hA5A5_5A5A, AXI_RESP_EXOKAY, 1'b1, 1'b0);
        zw_read("rC", 32'h0000_200C, 32'h0F0F_0F0F, AXI_RESP_OKAY, 1'b0, 1'b1);

        // Concurrent read + write, then a write accepted in the done cycle
        axi.M_AXI4_AWREADY = 1'b1; axi.M_AXI4_WREADY = 1'b1; axi.M_AXI4_ARREADY = 1'b1;
        c0 = wdone_cnt;
        biu_waddr = 32'h0000_5000; biu_wdata = 32'h1111_2222; biu_wben = 4'hC; biu_wenable = 1'b1;
        biu_raddr = 32'h0000_600C; biu_renable = 1'b1;
        tick();
        biu_wenable = 1'b0; biu_renable = 1'b0;
        check("cc_awvalid", 64'(axi.M_AXI4_AWVALID), 64'd1);
        check("cc_arvalid", 64'(axi.M_AXI4_ARVALID), 64'd1);
        check("cc_araddr", 64'(axi.M_AXI4_ARADDR), 64'h600C);
        tick();
        check("cc_bready", 64'(axi.M_AXI4_BREADY), 64'd1);
        check("cc_rready", 64'(axi.M_AXI4_RREADY), 64'd1);
        axi.M_AXI4_BVALID = 1'b1; axi.M_AXI4_BRESP = AXI_RESP_DECERR;
        axi.M_AXI4_RVALID = 1'b1; axi.M_AXI4_RDATA = 32'h0BAD_CAFE;
        axi.M_AXI4_RRESP = AXI_RESP_OKAY; axi.M_AXI4_RLAST = 1'b1;
        tick();
        axi.M_AXI4_BVALID = 1'b0; axi.M_AXI4_RVALID = 1'b0;
        check("cc_wdone", 64'(biu_wdone), 64'd1);
        check("cc_rdone", 64'(biu_rdone), 64'd1);
        check("cc_werror", 64'(biu_werror), 64'd1);
        check("cc_rdata", 64'(biu_rdata), 64'h0BADCAFE);
        check("cc_rerror", 64'(biu_rerror), 64'd0);
        check("b2b_waccept", 64'(biu_waccept), 64'd1);
        biu_waddr = 32'h0000_4000; biu_wdata = 32'h55AA_55AA; biu_wben = 4'hF; biu_wenable = 1'b1;
        tick();
        biu_wenable = 1'b0;
        check("b2b_awvalid", 64'(axi.M_AXI4_AWVALID), 64'd1);
        check("b2b_awaddr", 64'(axi.M_AXI4_AWADDR), 64'h4000);
        check("b2b_wdata", 64'(axi.M_AXI4_WDATA), 64'h55AA55AA);
        check("b2b_wdone_clr", 64'(biu_wdone), 64'd0);
        tick();
        check("b2b_bready", 64'(axi.M_AXI4_BREADY), 64'd1);
        axi.M_AXI4_BVALID = 1'b1; axi.M_AXI4_BRESP = AXI_RESP_EXOKAY;
        tick();
        axi.M_AXI4_BVALID = 1'b0;
        check("b2b_wdone", 64'(biu_wdone), 64'd1);
        check("b2b_werror", 64'(biu_werror), 64'd0);
        tick();
        check("b2b_wdone_count", 64'(wdone_cnt - c0), 64'd2);

        // Reset while waiting for B: transaction dropped, no done
        biu_waddr = 32'h0000_7000; biu_wdata = 32'h7777_7777; biu_wenable = 1'b1;
        tick();
        biu_wenable = 1'b0;
        tick();
        check("rstw_bready_pre", 64'(axi.M_AXI4_BREADY), 64'd1);
        c0 = wdone_cnt;
        rst_n = 1'b0;
        #1;
        check("rstw_bready", 64'(axi.M_AXI4_BREADY), 64'd0);
        check("rstw_awvalid", 64'(axi.M_AXI4_AWVALID), 64'd0);
        check("rstw_wvalid", 64'(axi.M_AXI4_WVALID), 64'd0);
        check("rstw_waccept", 64'(biu_waccept), 64'd1);
        check("rstw_awaddr", 64'(axi.M_AXI4_AWADDR), 64'd0);
        axi.M_AXI4_BVALID = 1'b1; axi.M_AXI4_BRESP = AXI_RESP_SLVERR;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("rstw_bready_after", 64'(axi.M_AXI4_BREADY), 64'd0);
        check("rstw_no_wdone", 64'(wdone_cnt - c0), 64'd0);
        check("rstw_werror", 64'(biu_werror), 64'd0);
        axi.M_AXI4_BVALID = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vxe_axi4mas_biu.md
# vxe_axi4mas_biu

AXI4 master bus interface unit: converts a simple single-word request/done client interface into AXI4 master transactions. It is the initiator counterpart of the AXI4 slave BIU and sits between VxEngine internal masters (the DMA/fetch logic) and the system interconnect. Read and write paths are independent. Each path carries at most one outstanding single-beat transaction.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (32 or 64)
- ID_WIDTH, 8, AXI ID width
- AXI_ID, 0, constant value driven on AWID/ARID

Ports:
- M_AXI4_ACLK  in  1  clock
- M_AXI4_ARESETn  in  1  asynchronous active-low reset
- M_AXI4_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWPROT  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/3  write address
- M_AXI4_AWVALID out 1; M_AXI4_AWREADY in 1
- M_AXI4_WDATA/WSTRB/WLAST  out  DATA_WIDTH/DATA_WIDTH/8/1; M_AXI4_WVALID out 1; M_AXI4_WREADY in 1
- M_AXI4_BID in ID_WIDTH; M_AXI4_BRESP in 2; M_AXI4_BVALID in 1; M_AXI4_BREADY out 1
- M_AXI4_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARPROT  out  as AW; M_AXI4_ARVALID out 1; M_AXI4_ARREADY in 1
- M_AXI4_RID in ID_WIDTH; M_AXI4_RDATA in DATA_WIDTH; M_AXI4_RRESP in 2; M_AXI4_RLAST in 1; M_AXI4_RVALID in 1; M_AXI4_RREADY out 1
- biu_waddr in ADDR_WIDTH; biu_wdata in DATA_WIDTH; biu_wben in DATA_WIDTH/8; biu_wenable in 1: write request
- biu_waccept out 1: write request taken when biu_wenable && biu_waccept
- biu_wdone out 1: one-cycle pulse, write completed; biu_werror out 1: valid with biu_wdone
- biu_raddr in ADDR_WIDTH; biu_renable in 1; biu_raccept out 1
- biu_rdone out 1: one-cycle pulse; biu_rdata out DATA_WIDTH; biu_rerror out 1: valid with biu_rdone

## Operation
- Constant outputs: AxLEN=0, AxSIZE=log2(DATA_WIDTH/8), AxBURST=INCR (2'b01), AxLOCK=0, AxPROT=3'b000, AxID=AXI_ID, WLAST=1.
- Write FSM: W_IDLE -> W_REQ -> W_RESP -> W_IDLE.
  - W_IDLE: biu_waccept=1. On biu_wenable, capture addr/data/ben, set awpend=wpend=1, go to W_REQ.
  - W_REQ: AWVALID=awpend, WVALID=wpend. Each flag clears on its own handshake (AW and W handshakes are independent; either order or the same cycle). Go to W_RESP when both are clear, or clearing in this cycle.
  - W_RESP: BREADY=1. On BVALID, latch error = BRESP[1], pulse biu_wdone next cycle, go to W_IDLE.
- Read FSM: R_IDLE -> R_ADDR -> R_RESP -> R_IDLE.
  - R_IDLE: biu_raccept=1. Capture addr on biu_renable.
  - R_ADDR: ARVALID=1 until ARREADY.
  - R_RESP: RREADY=1. On RVALID, latch RDATA; error = RRESP[1] | ~RLAST.
- biu_rdata/biu_werror/biu_rerror hold their last value until the next done.
- EXOKAY and OKAY are both success. SLVERR and DECERR are both errors.
- BID/RID are ignored (single outstanding).
- Payload registers hold a constant value while the corresponding VALID is high (AXI stability).

## Timing
- Reset values: all VALID=0, BREADY=RREADY=0, biu_wdone=biu_rdone=0, biu_waccept=biu_raccept=1 (IDLE), biu_werror=biu_rerror=0, biu_rdata=0, address/data outputs=0.
- Accept at cycle N -> AWVALID/WVALID/ARVALID high at N+1.
- Zero-wait slave: handshake at N+1, BREADY/RREADY at N+2, response at N+2, done pulse at N+3.
- Done is a registered pulse. The FSM is in IDLE during the done cycle, so the next request can be accepted in the same cycle as done.
- Read and write may run concurrently with no mutual ordering.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately, the transaction is dropped, and no done pulse is issued.
- RVALID/BVALID arriving while not in the RESP state are not accepted (READY low).

## Structure
- Shared package/header vxe_axi4_defs: response codes OKAY/EXOKAY/SLVERR/DECERR and burst codes FIXED/INCR/WRAP. This package is shared with vxe_axi4slv_biu.
- FSM state encodings are local to this module.
- Single module, no sub-modules. Read and write paths are two independent always-block groups.

## Test plan
- Write addr 0x1000, data 0xDEADBEEF, ben 0xF, zero-wait slave, BRESP=OKAY -> AW/W valid at N+1, biu_wdone at N+3, biu_werror=0.
- Slave drives WREADY 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID stays high with stable payload, one B accepted, biu_wdone once.
- Read addr 0x2004, RDATA 0x12345678, RRESP=SLVERR after 5-cycle ARREADY stall -> biu_rdone, biu_rdata=0x12345678, biu_rerror=1. Repeat with RRESP=EXOKAY -> biu_rerror=0.
- Read response with RLAST=0 -> biu_rerror=1.
- Concurrent read and write, then back-to-back writes issued in the done cycle -> both paths complete independently, second write accepted with no idle cycle.
- Reset asserted while in W_RESP -> all VALID/READY=0, biu_waccept=1, no biu_wdone pulse.
